// File: rtl/intra_edge_filter_strength_sel.sv
// AV1 intra edge filter strength selection: maps block size, smooth flag and
// angle delta to a 0..3 strength, registered once per clock.
module intra_edge_filter_strength_sel (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] w,
  input  logic [9:0] h,
  input  logic [9:0] filterType,
  input  logic [9:0] delta,
  output logic [9:0] filter_strength
);

  localparam int unsigned DW  = 10;
  localparam int unsigned EW  = DW + 1;
  localparam int unsigned SW  = 2;

  logic [EW-1:0] w_delta_sx;
  logic [EW-1:0] w_d;
  logic [EW-1:0] w_blkwh;
  logic          w_smooth;
  logic [SW-1:0] w_strength;
  logic [SW-1:0] r_strength;

  // Magnitude is one bit wider so the most negative delta does not wrap.
  assign w_delta_sx = {delta[DW-1], delta};
  assign w_d        = delta[DW-1] ? (EW'(0) - w_delta_sx) : w_delta_sx;
  assign w_blkwh    = EW'(w) + EW'(h);
  assign w_smooth   = |filterType;

  // Thresholds are ascending within a class, so later matches override earlier ones.
  always_comb begin
    w_strength = SW'(0);
    if (!w_smooth) begin
      if (w_blkwh <= EW'(8)) begin
        if (w_d >= EW'(56)) w_strength = SW'(1);
      end else if (w_blkwh <= EW'(16)) begin
        if (w_d >= EW'(40)) w_strength = SW'(1);
      end else if (w_blkwh <= EW'(24)) begin
        if (w_d >= EW'(8))  w_strength = SW'(1);
        if (w_d >= EW'(16)) w_strength = SW'(2);
        if (w_d >= EW'(32)) w_strength = SW'(3);
      end else if (w_blkwh <= EW'(32)) begin
        if (w_d >= EW'(1))  w_strength = SW'(1);
        if (w_d >= EW'(4))  w_strength = SW'(2);
        if (w_d >= EW'(32)) w_strength = SW'(3);
      end else begin
        if (w_d >= EW'(1))  w_strength = SW'(3);
      end
    end else begin
      if (w_blkwh <= EW'(8)) begin
        if (w_d >= EW'(40)) w_strength = SW'(1);
        if (w_d >= EW'(64)) w_strength = SW'(2);
      end else if (w_blkwh <= EW'(16)) begin
        if (w_d >= EW'(20)) w_strength = SW'(1);
        if (w_d >= EW'(48)) w_strength = SW'(2);
      end else if (w_blkwh <= EW'(24)) begin
        if (w_d >= EW'(4))  w_strength = SW'(3);
      end else begin
        if (w_d >= EW'(1))  w_strength = SW'(3);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strength <= SW'(0);
    end else begin
      r_strength <= w_strength;
    end
  end

  assign filter_strength = {(DW - SW)'(0), r_strength};

endmodule

// File: tb/tb_intra_edge_filter_strength_sel.sv
// Randomized and directed check of intra_edge_filter_strength_sel against a
// threshold-table reference model; one result expected per clock, one cycle late.
module tb_intra_edge_filter_strength_sel;

  logic       clk;
  logic       rst_n;
  logic [9:0] w;
  logic [9:0] h;
  logic [9:0] filterType;
  logic [9:0] delta;
  logic [9:0] filter_strength;

  int unsigned n_cmp;
  int unsigned n_err;
  bit          pinned;

  logic [9:0] exp_q;
  bit         lit_in_v;
  logic [9:0] lit_in;
  bit         lit_q_v;
  logic [9:0] lit_q;

  intra_edge_filter_strength_sel dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .w              (w),
    .h              (h),
    .filterType     (filterType),
    .delta          (delta),
    .filter_strength(filter_strength)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: pick the three level thresholds for the block class, then
  // report the highest level whose threshold the magnitude reaches.
  function automatic int ref_strength(int wi, int hi, int ft, int sd);
    int d;
    int blk;
    int t1;
    int t2;
    int t3;
    d   = (sd < 0) ? -sd : sd;
    blk = wi + hi;
    t1 = 100000; t2 = 100000; t3 = 100000;
    if (ft == 0) begin
      if (blk <= 8)       t1 = 56;
      else if (blk <= 16) t1 = 40;
      else if (blk <= 24) begin t1 = 8; t2 = 16; t3 = 32; end
      else if (blk <= 32) begin t1 = 1; t2 = 4;  t3 = 32; end
      else                begin t1 = 1; t2 = 1;  t3 = 1;  end
    end else begin
      if (blk <= 8)       begin t1 = 40; t2 = 64; end
      else if (blk <= 16) begin t1 = 20; t2 = 48; end
      else if (blk <= 24) begin t1 = 4;  t2 = 4;  t3 = 4; end
      else                begin t1 = 1;  t2 = 1;  t3 = 1; end
    end
    if (d == 0)       return 0;
    else if (d >= t3) return 3;
    else if (d >= t2) return 2;
    else if (d >= t1) return 1;
    else              return 0;
  endfunction

  // Expected output register, with the same asynchronous clear behaviour.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= 10'd0;
    else        exp_q <= 10'(ref_strength(int'(w), int'(h), int'(filterType),
                                         int'($signed(delta))));
  end

  always @(posedge clk) begin
    lit_q_v <= rst_n && lit_in_v;
    lit_q   <= lit_in;
  end

  task automatic chk(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Single checker: model pins once, then model, literal and reset checks each cycle.
  always @(negedge clk) begin
    if (!pinned) begin
      pinned = 1'b1;
      chk("pin_s44_65",   ref_strength(4, 4, 1, 65), 2);
      chk("pin_n816_m32", ref_strength(8, 16, 0, -32), 3);
      chk("pin_n1616_3",  ref_strength(16, 16, 0, 3), 1);
      chk("pin_s44_m512", ref_strength(4, 4, 5, -512), 2);
      chk("pin_n3232_0",  ref_strength(32, 32, 0, 0), 0);
      chk("pin_s88_19",   ref_strength(8, 8, 5, 19), 0);
    end
    if (!rst_n) begin
      chk("reset_zero", int'(filter_strength), 0);
    end else begin
      chk("model", int'(filter_strength), int'(exp_q));
      if (lit_q_v) chk("directed", int'(filter_strength), int'(lit_q));
    end
  end

  task automatic step(int wi, int hi, int ft, int sd, bit lv, int lexp);
    @(posedge clk);
    #2;
    w          = 10'(wi);
    h          = 10'(hi);
    filterType = 10'(ft);
    delta      = 10'(sd);
    lit_in_v   = lv;
    lit_in     = 10'(lexp);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; pinned = 1'b0;
    lit_in_v = 1'b0; lit_in = 10'd0;
    rst_n = 1'b0;
    w = 10'd4; h = 10'd4; filterType = 10'd1; delta = 10'd65;
    repeat (3) @(posedge clk);
    #2;
    rst_n    = 1'b1;
    lit_in_v = 1'b1;
    lit_in   = 10'd2;

    step(4, 4, 1, 39, 1, 0);
    step(4, 4, 1, 40, 1, 1);
    step(4, 4, 1, 63, 1, 1);
    step(4, 4, 1, 64, 1, 2);
    step(4, 4, 1, 65, 1, 2);
    step(8, 16, 0, 7, 1, 0);
    step(8, 16, 0, 8, 1, 1);
    step(8, 16, 0, 16, 1, 2);
    step(8, 16, 0, 32, 1, 3);
    step(8, 16, 0, -32, 1, 3);
    step(16, 16, 0, 3, 1, 1);
    step(16, 16, 0, 4, 1, 2);
    step(32, 32, 0, 1, 1, 3);
    step(32, 32, 0, 0, 1, 0);
    step(4, 4, 0, 55, 1, 0);
    step(4, 4, 0, 56, 1, 1);
    step(16, 16, 5, -1, 1, 3);
    step(8, 8, 5, 19, 1, 0);
    step(8, 8, 5, 20, 1, 1);
    step(8, 8, 5, 48, 1, 2);
    step(4, 4, 5, -512, 1, 2);
    step(8, 16, 0, 32, 1, 3);

    // Reset asserted between edges must clear the output before the next edge.
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    lit_in_v = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    w = 10'd8; h = 10'd16; filterType = 10'd0; delta = 10'd16;
    lit_in_v = 1'b1; lit_in = 10'd2;

    for (int i = 0; i < 3000; i++) begin
      int wi, hi, ft, sd;
      if ($urandom_range(9) == 0) begin
        wi = int'($urandom_range(1023));
        hi = int'($urandom_range(1023));
      end else begin
        wi = int'($urandom_range(64, 4));
        hi = int'($urandom_range(64, 4));
      end
      ft = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(1023, 1));
      if ($urandom_range(1) == 0) sd = int'($urandom_range(140)) - 70;
      else                        sd = int'($urandom_range(1023)) - 512;
      step(wi, hi, ft, sd, 0, 0);
      if (i == 1500) begin
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #4;
        rst_n = 1'b1;
      end
    end

    repeat (3) @(posedge clk);
    #7;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
